axil_mem_read_slave: RTL



---
 rtl/axil_mem_read_slave.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/axil_mem_read_slave.sv
// rtl/axil_mem_read_slave.sv - AXI-lite read-only slave backed by a synchronous memory array
//
// Serves AXI-lite read transactions from an on-chip word memory. A local write
// port preloads or updates the memory contents. At most one read is outstanding.
// A new read can be accepted in the same cycle the previous beat completes, so
// the slave sustains one beat per cycle while rready is high.
//
// Optional build macro: AXIL_MEM_READ_STATS_EN
//   When defined, the rd_count and err_count outputs are added.
//   When undefined, those ports and their counters are absent.
//
// Ports:
//   s_axil_aclk     clock for all logic
//   s_axil_rstn     synchronous active-low reset
//   s_axil_araddr   read byte address
//   s_axil_arprot   protection bits; ignored
//   s_axil_arvalid  address valid
//   s_axil_arready  address accept; combinational, !rvalid || rready
//   s_axil_rdata    read data; zero on an error beat
//   s_axil_rresp    2'b00 OKAY, 2'b10 SLVERR (out of range or misaligned)
//   s_axil_rvalid   read data valid
//   s_axil_rready   read data accept
//   wr_en           local memory write strobe
//   wr_addr         local write word index; writes at or beyond MEM_DEPTH are ignored
//   wr_data         local write data
//   rd_count        (stats build) R handshakes; wraps
//   err_count       (stats build) SLVERR R handshakes; saturates at 16'hFFFF

module axil_mem_read_slave #(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDR_WIDTH    = 32,
  parameter int MEM_DEPTH     = 1024,
  parameter int WR_ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
  input  logic                     s_axil_aclk,
  input  logic                     s_axil_rstn,
  input  logic [ADDR_WIDTH-1:0]    s_axil_araddr,
  input  logic [2:0]               s_axil_arprot,
  input  logic                     s_axil_arvalid,
  output logic                     s_axil_arready,
  output logic [DATA_WIDTH-1:0]    s_axil_rdata,
  output logic [1:0]               s_axil_rresp,
  output logic                     s_axil_rvalid,
  input  logic                     s_axil_rready,
  input  logic                     wr_en,
  input  logic [WR_ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0]    wr_data
`ifdef AXIL_MEM_READ_STATS_EN
  ,
  output logic [31:0]              rd_count,
  output logic [15:0]              err_count
`endif
);

  localparam int BSH    = $clog2(DATA_WIDTH / 8);
  localparam int IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  // The word index is widened so that the range check sees every address bit
  // and can never wrap into a valid index.
  localparam int EXT_W  = ADDR_WIDTH + 32;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  state_t state, state_next;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic [EXT_W-1:0] word_idx;
  logic             misaligned;
  logic             in_range;
  logic             ar_hs;
  logic             r_hs;

  // arprot is ignored by this slave.
  logic unused_arprot;
  assign unused_arprot = ^s_axil_arprot;

  assign word_idx   = EXT_W'(s_axil_araddr) >> BSH;
  assign misaligned = (s_axil_araddr & ADDR_WIDTH'((1 << BSH) - 1)) != '0;
  assign in_range   = word_idx < EXT_W'(MEM_DEPTH);

  assign s_axil_rvalid  = (state == RESP);
  assign s_axil_arready = !s_axil_rvalid || s_axil_rready;
  assign ar_hs          = s_axil_arvalid && s_axil_arready;
  assign r_hs           = s_axil_rvalid && s_axil_rready;

  always_ff @(posedge s_axil_aclk) begin
    if (!s_axil_rstn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A new AR wins over completion, so the response channel stays busy with the
  // new beat; a completed beat with no new AR returns to IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (ar_hs) state_next = RESP;
      RESP: begin
        if (ar_hs) begin
          state_next = RESP;
        end else if (s_axil_rready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Memory contents survive reset. The read below samples the array in the same
  // edge as this write, which gives read-first behaviour on a collision.
  always_ff @(posedge s_axil_aclk) begin
    if (wr_en && (32'(wr_addr) < 32'(MEM_DEPTH))) begin
      mem[IDX_W'(wr_addr)] <= wr_data;
    end
  end

  // The read is enabled only on an AR handshake, so the data and response
  // stay stable while a beat is stalled.
  always_ff @(posedge s_axil_aclk) begin
    if (!s_axil_rstn) begin
      s_axil_rdata <= '0;
      s_axil_rresp <= RESP_OKAY;
    end else if (ar_hs) begin
      if (in_range && !misaligned) begin
        s_axil_rdata <= mem[word_idx[IDX_W-1:0]];
        s_axil_rresp <= RESP_OKAY;
      end else begin
        s_axil_rdata <= '0;
        s_axil_rresp <= RESP_SLVERR;
      end
    end
  end

`ifdef AXIL_MEM_READ_STATS_EN
  always_ff @(posedge s_axil_aclk) begin
    if (!s_axil_rstn) begin
      rd_count  <= '0;
      err_count <= '0;
    end else if (r_hs) begin
      rd_count <= rd_count + 32'd1;
      if (s_axil_rresp == RESP_SLVERR && err_count != 16'hFFFF) begin
        err_count <= err_count + 16'd1;
      end
    end
  end
`else
  logic unused_r_hs;
  assign unused_r_hs = r_hs;
`endif

endmodule
